// File: rtl/memory_access_unit_pkg.sv
// Shared constants for the memory access unit: FSM state encoding,
// default bus widths and the wait-counter width.
package memory_access_unit_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int CNT_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // The unit is busy in every state other than IDLE.
    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Bundle of the control-unit request/response signals and the memory-side
// handshake. master = the access unit, slave = its environment.
interface memory_access_unit_if
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    // Control-unit side
    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] output_MDR;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  start, wr_en, addr, wdata, mem_rdata, mem_ack,
        output busy, done, err, output_MDR, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, wr_en, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, err, output_MDR, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/wait_counter.sv
// Saturating wait-cycle counter: clear has priority over enable, and the
// count sticks at all-ones instead of wrapping.
module wait_counter
    import memory_access_unit_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count enabled cycles, saturating at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/memory_access_unit.sv
// Single-access memory sequencer: latches a request from the control unit,
// issues a one-cycle memory strobe, waits for an acknowledge with a bounded
// timeout and reports done or err. Reads land in output_MDR.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    memory_access_unit_if.master bus
);

    // The counter has counted TIMEOUT-1 idle WAIT cycles; one more idle
    // cycle makes TIMEOUT, which is the cycle that times out.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg;
    logic              done_reg;
    logic              err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] mdr_reg;

    logic              cnt_clear;
    logic              cnt_enable;
    logic [CNT_W-1:0]  wait_count;
    logic              timeout_hit;

    assign cnt_clear   = (state_reg == ST_REQ);
    assign cnt_enable  = (state_reg == ST_WAIT) && !bus.mem_ack;
    assign timeout_hit = (wait_count == TIMEOUT_LAST);

    wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (wait_count)
    );

    // Access sequencer with registered outputs; done/err/mem_req are single
    // cycle pulses produced on entry to their states.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mdr_reg       <= '0;
        end else begin
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            mem_req_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        mem_addr_reg  <= bus.addr;
                        mem_wdata_reg <= bus.wdata;
                        mem_we_reg    <= bus.wr_en;
                        mem_req_reg   <= 1'b1;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack on the timeout cycle still completes the access.
                    if (bus.mem_ack) begin
                        if (!mem_we_reg) begin
                            mdr_reg <= bus.mem_rdata;
                        end
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = state_is_busy(state_reg);
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.output_MDR = mdr_reg;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit. Each access is described by
// its direction, data and the number of ack-less WAIT cycles before the
// memory answers; the expected cycle-by-cycle outputs are derived from that
// description alone.
module tb_memory_access_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] model_mdr;

    memory_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_access_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),       32'd0);
        chk({tag, "_done"},  32'(bus.done),       32'd0);
        chk({tag, "_err"},   32'(bus.err),        32'd0);
        chk({tag, "_req"},   32'(bus.mem_req),    32'd0);
        chk({tag, "_we"},    32'(bus.mem_we),     32'd0);
        chk({tag, "_addr"},  32'(bus.mem_addr),   32'd0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata),  32'd0);
        chk({tag, "_mdr"},   32'(bus.output_MDR), 32'd0);
    endtask

    // One access. ack_at = number of WAIT cycles without ack before the ack;
    // ack_at >= TIMEOUT means the memory never answers in time.
    // hold keeps start high for the whole access.
    task automatic run_access(input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                              input int ack_at, input bit hold);
        bit                ok;
        int                e;
        logic [DATA_W-1:0] exp_mdr_after;
        ok            = (ack_at < TIMEOUT);
        e             = ok ? (3 + ack_at) : (2 + TIMEOUT);
        exp_mdr_after = (ok && !wr) ? rd : model_mdr;

        // Cycle 0: idle, issue the request (plus a possible stray ack).
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_err",  32'(bus.err),  32'd0);
        chk("idle_mdr",  32'(bus.output_MDR), 32'(model_mdr));
        bus.start     = 1'b1;
        bus.wr_en     = wr;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = DATA_W'($urandom);

        for (int c = 1; c <= e; c++) begin
            @(negedge clk);
            chk("busy",      32'(bus.busy),      32'd1);
            chk("mem_req",   32'(bus.mem_req),   32'(c == 1));
            chk("done",      32'(bus.done),      32'(ok && (c == e)));
            chk("err",       32'(bus.err),       32'(!ok && (c == e)));
            chk("mem_we",    32'(bus.mem_we),    32'(wr));
            chk("mem_addr",  32'(bus.mem_addr),  32'(a));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
            chk("mdr", 32'(bus.output_MDR), 32'((c < e) ? model_mdr : exp_mdr_after));
            $display("  cyc %0d/%0d wr=%0b addr=%h busy=%0b done=%0b err=%0b mdr=%h",
                     c, e, wr, a, bus.busy, bus.done, bus.err, bus.output_MDR);

            // Requests raised while busy must be dropped.
            bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.addr  = ADDR_W'($urandom);
            bus.wdata = DATA_W'($urandom);
            if (c == 2 + ack_at) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
            end else if (c == 1 || c == e) begin
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = DATA_W'($urandom);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = DATA_W'($urandom);
            end
        end
        model_mdr = exp_mdr_after;
        $display("access wr=%0b addr=%h wdata=%h ack_at=%0d -> %s mdr=%h",
                 wr, a, wd, ack_at, ok ? "done" : "err", model_mdr);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        model_mdr     = '0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Read, ack on first WAIT cycle
        run_access(1'b0, 16'h0040, 16'h0000, 16'hABCD, 0, 1'b0);
        // Write, ack after 3 WAIT cycles: MDR untouched
        run_access(1'b1, 16'h0010, 16'h1234, 16'hFFFF, 3, 1'b0);
        // Read with no ack: timeout, MDR keeps 0xABCD
        run_access(1'b0, 16'h0020, 16'h0000, 16'h9999, TIMEOUT + 10, 1'b0);
        // Ack coincident with the timeout cycle: ack wins
        run_access(1'b0, 16'h0030, 16'h0000, 16'h5678, TIMEOUT - 1, 1'b0);
        // Ack arriving one cycle too late lands in ERR and is ignored
        run_access(1'b0, 16'h0031, 16'h0000, 16'h4321, TIMEOUT, 1'b0);
        // Back-to-back with start held high
        run_access(1'b0, 16'h0100, 16'h0000, 16'h1111, 1, 1'b1);
        run_access(1'b0, 16'h0104, 16'h0000, 16'h2222, 2, 1'b1);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            run_access(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                       DATA_W'($urandom), int'($urandom_range(0, TIMEOUT + 2)),
                       ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of WAIT
        @(negedge clk);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b0;
        bus.addr    = 16'h0040;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("midrst_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_wait_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst_async");
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.done), 32'd0);
            chk("midrst_no_err",  32'(bus.err),  32'd0);
        end
        bus.mem_ack = 1'b0;
        model_mdr   = '0;
        $display("reset mid-WAIT applied");
        @(posedge clk);
        #1 rst_n = 1'b1;
        // First edge after release must accept the request
        run_access(1'b0, 16'h0050, 16'h0000, 16'hBEEF, 0, 1'b0);

        @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_mdr",  32'(bus.output_MDR), 32'(model_mdr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter DATA_W, default 16, data and memory-data-register width.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before an error is flagged; legal range 1..255.
REQ-004 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  single rising-edge clock.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 start  input  1  control-unit request; sampled only in IDLE.
REQ-008 wr_en  input  1  1 = write access, 0 = read access; sampled with start.
REQ-009 addr  input  ADDR_W  access address; sampled with start.
REQ-010 wdata  input  DATA_W  write data; sampled with start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 err  output  1  one-cycle pulse on timeout.
REQ-014 output_MDR  output  DATA_W  memory data register, feeding the downstream simple register.
REQ-015 mem_req  output  1  memory request strobe.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  ADDR_W  registered memory address.
REQ-018 mem_wdata  output  DATA_W  registered memory write data.
REQ-019 mem_rdata  input  DATA_W  memory read data; valid when mem_ack is high.
REQ-020 mem_ack  input  1  memory acknowledge; one cycle per access.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DONE, ERR.
REQ-022 IDLE with start=1 SHALL capture addr, wdata, and wr_en into mem_addr, mem_wdata, and mem_we, then go to REQ; with start=0 it SHALL stay in IDLE.
REQ-023 REQ SHALL assert mem_req for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-024 WAIT with mem_ack=1 SHALL go to DONE; on a read, output_MDR SHALL load mem_rdata on that edge.
REQ-025 WAIT with mem_ack=0 SHALL increment the wait counter; when the counter equals TIMEOUT it SHALL go to ERR.
REQ-026 When mem_ack=1 in the same cycle the counter reaches TIMEOUT, the ack SHALL win and the FSM SHALL go to DONE.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE.
REQ-028 ERR SHALL assert err for one cycle, return to IDLE, and leave output_MDR unchanged.
REQ-029 A write access SHALL never modify output_MDR.
REQ-030 start asserted while busy=1 SHALL be ignored and not queued.
REQ-031 mem_ack received outside WAIT SHALL be ignored.
REQ-032 mem_addr, mem_wdata, and mem_we SHALL hold stable from REQ through DONE or ERR.
REQ-033 Minimum latency SHALL be 4 cycles from start sampled to done (IDLE, REQ, WAIT with ack, DONE).
REQ-034 output_MDR SHALL hold its value indefinitely between reads.
REQ-035 The wait counter SHALL be 8 bits wide and SHALL never wrap.

Reset
REQ-036 RESET_N low SHALL asynchronously force state IDLE and set busy, done, err, mem_req, and mem_we to 0.
REQ-037 RESET_N low SHALL asynchronously clear mem_addr, mem_wdata, output_MDR, and the wait counter to 0.
REQ-038 Reset asserted mid-access SHALL abort the access with no done or err pulse.
REQ-039 After reset release, the first rising edge SHALL sample start normally.

Structure
REQ-040 The state encoding and default widths SHALL reside in the shared processor constants package.
REQ-041 The wait counter SHALL be one sub-module, wait_counter, with clear, enable, and count ports.
REQ-042 All outputs SHALL be registered, except busy, which SHALL be decoded from state.

Verification
REQ-043 Reset mid-WAIT: start read, then drop RESET_N during WAIT -> state IDLE, all outputs 0, no done or err pulse.
REQ-044 Read with ack on the first WAIT cycle, addr=16'h0040, mem_rdata=16'hABCD -> done 4 cycles after start, output_MDR=16'hABCD.
REQ-045 Write with addr=16'h0010, wdata=16'h1234, ack after 3 wait cycles -> mem_we=1 and mem_wdata=16'h1234 held throughout, done pulses, output_MDR unchanged.
REQ-046 Read with no ack and TIMEOUT=15 -> err pulses after 15 WAIT cycles, output_MDR keeps its prior value 16'hABCD.
REQ-047 Ack coincident with the counter reaching TIMEOUT, mem_rdata=16'h5678 -> done pulses, err stays 0, output_MDR=16'h5678.
REQ-048 Back-to-back accesses with start held high: the second start is ignored while busy, a new access begins on the cycle after DONE returns to IDLE, and a stray mem_ack in IDLE has no effect.
